// File: rtl/yacht_pkg.sv
// Shared definitions for the Yacht scorecard slice.
//   - category indices CAT_ONES..CAT_YACHT (0-5 upper, 6-11 lower)
//   - scorecard sizing: NUM_CAT, UPPER_CNT, SCORE_W, TOTAL_W, CAT_W, UPPER_W
//   - upper-section bonus rule: BONUS_THRESH, BONUS_VAL
//   - commit/undo FSM state encoding (state_t)
package yacht_pkg;

  localparam int NUM_CAT      = 12;
  localparam int UPPER_CNT    = 6;
  localparam int SCORE_W      = 8;
  localparam int TOTAL_W      = 9;
  localparam int CAT_W        = 4;
  // Wide enough for six full-scale 8-bit scores, so bonus detection never wraps.
  localparam int UPPER_W      = 11;
  localparam int BONUS_THRESH = 63;
  localparam int BONUS_VAL    = 35;

  localparam int CAT_ONES        = 0;
  localparam int CAT_TWOS        = 1;
  localparam int CAT_THREES      = 2;
  localparam int CAT_FOURS       = 3;
  localparam int CAT_FIVES       = 4;
  localparam int CAT_SIXES       = 5;
  localparam int CAT_CHOICE      = 6;
  localparam int CAT_FOUR_KIND   = 7;
  localparam int CAT_FULL_HOUSE  = 8;
  localparam int CAT_SM_STRAIGHT = 9;
  localparam int CAT_LG_STRAIGHT = 10;
  localparam int CAT_YACHT       = 11;

  // S_UNDO / S_UNDO_ACK are only reachable when SCORECARD_UNDO_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_SUM,
    S_ERR,
    S_UNDO,
    S_UNDO_ACK
  } state_t;

endpackage

// File: rtl/score_bank.sv
// One player's scorecard.
// Holds the per-category score registers, the used-category mask and the
// upper-bonus flag. The total and the upper sum are derived from the stored
// scores, so a write or an undo is a single register update.
// Ports:
//   clk, clear        clock; synchronous clear of the whole card
//   wr_en/wr_cat/wr_score        store a score and mark the category used
//   undo_en/undo_cat/undo_bonus  forget a category (and the bonus if it caused it)
//   used_mask         bit i = category i used
//   total             sum of scores plus bonus (wraps at TOTAL_W)
//   bonus             upper bonus awarded
module score_bank
  import yacht_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [CAT_W-1:0]   wr_cat,
  input  logic [SCORE_W-1:0] wr_score,
  input  logic               undo_en,
  input  logic [CAT_W-1:0]   undo_cat,
  input  logic               undo_bonus,
  output logic [NUM_CAT-1:0] used_mask,
  output logic [TOTAL_W-1:0] total,
  output logic               bonus
);

  logic [SCORE_W-1:0] scores [NUM_CAT];
  logic [UPPER_W-1:0] upper_sum;
  logic [UPPER_W-1:0] upper_next;
  logic [TOTAL_W-1:0] raw_sum;
  logic               bonus_hit;

  always_comb begin
    upper_sum = '0;
    raw_sum   = '0;
    for (int i = 0; i < NUM_CAT; i++) begin
      raw_sum = raw_sum + TOTAL_W'(scores[i]);
      if (i < UPPER_CNT) upper_sum = upper_sum + UPPER_W'(scores[i]);
    end
    // Upper sum as it will be once the pending write lands.
    upper_next = upper_sum;
    if (wr_cat < CAT_W'(UPPER_CNT)) upper_next = upper_sum + UPPER_W'(wr_score);
    bonus_hit = !bonus && (upper_next >= UPPER_W'(BONUS_THRESH));
  end

  assign total = raw_sum + (bonus ? TOTAL_W'(BONUS_VAL) : '0);

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_CAT; i++) scores[i] <= '0;
      used_mask <= '0;
      bonus     <= 1'b0;
    end else if (wr_en) begin
      scores[wr_cat]    <= wr_score;
      used_mask[wr_cat] <= 1'b1;
      if (bonus_hit) bonus <= 1'b1;
    end else if (undo_en) begin
      scores[undo_cat]    <= '0;
      used_mask[undo_cat] <= 1'b0;
      if (undo_bonus) bonus <= 1'b0;
    end
  end

endmodule

// File: rtl/scorecard_manager.sv
// Owns both players' Yacht scorecards: validates category commits from the
// game FSM, writes the candidate score into the right player's score_bank,
// and reports used masks, totals, bonus flags and game_over.
// Optional feature macro: SCORECARD_UNDO_EN (adds undo_req / undo_ack and a
// one-deep undo of the last committed category).
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   new_game              synchronous clear of both cards, aborts any commit
//   player, cat_idx, cand_score, commit_req   commit request (sampled in IDLE)
//   commit_ack, commit_err   1-cycle result pulses, 3 cycles after the request
//   busy                  commit (or undo) in flight
//   used_mask_p1/p2, p1_total/p2_total, bonus_p1/p2   per-player card state
//   game_over             both masks full
//   undo_req, undo_ack    (SCORECARD_UNDO_EN only)
// Handshake: commit_req is a 1-cycle pulse accepted only while busy is low;
// a request seen while busy is dropped, never queued. Exactly one of
// commit_ack/commit_err follows each accepted request unless new_game aborts it.
module scorecard_manager
  import yacht_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               player,
  input  logic [CAT_W-1:0]   cat_idx,
  input  logic [SCORE_W-1:0] cand_score,
  input  logic               commit_req,
`ifdef SCORECARD_UNDO_EN
  input  logic               undo_req,
  output logic               undo_ack,
`endif
  output logic               commit_ack,
  output logic               commit_err,
  output logic               busy,
  output logic [NUM_CAT-1:0] used_mask_p1,
  output logic [NUM_CAT-1:0] used_mask_p2,
  output logic [TOTAL_W-1:0] p1_total,
  output logic [TOTAL_W-1:0] p2_total,
  output logic               bonus_p1,
  output logic               bonus_p2,
  output logic               game_over
);

  state_t               state;
  state_t               next_state;
  logic                 player_q;
  logic [CAT_W-1:0]     cat_q;
  logic [SCORE_W-1:0]   score_q;
  logic                 err_q;
  logic                 clear;
  logic [(1<<CAT_W)-1:0] sel_mask_ext;
  logic                 cat_bad;
  logic                 wr_go;
  logic                 undo_start;
  logic                 undo_p1;
  logic                 undo_p2;
  logic [CAT_W-1:0]     undo_cat;
  logic                 undo_bonus;

  assign clear = reset | new_game;

  // Widened so an out-of-range cat_q indexes a zero instead of past the mask.
  assign sel_mask_ext = {{((1<<CAT_W)-NUM_CAT){1'b0}},
                         (player_q ? used_mask_p2 : used_mask_p1)};
  assign cat_bad = (cat_q >= CAT_W'(NUM_CAT)) || sel_mask_ext[cat_q];
  assign wr_go   = (state == S_WRITE);

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= S_IDLE;
      player_q <= 1'b0;
      cat_q    <= '0;
      score_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;
      // Registered so the error pulse lands in the same cycle slot as ack.
      err_q <= (state == S_ERR);
      if (state == S_IDLE && commit_req) begin
        player_q <= player;
        cat_q    <= cat_idx;
        score_q  <= cand_score;
      end
    end
  end

  always_comb begin
    next_state = state;
    commit_ack = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (commit_req)      next_state = S_CHECK;
        else if (undo_start) next_state = S_UNDO;
      end
      S_CHECK:    next_state = cat_bad ? S_ERR : S_WRITE;
      S_WRITE:    next_state = S_SUM;
      S_SUM: begin
        commit_ack = 1'b1;
        next_state = S_IDLE;
      end
      S_ERR:      next_state = S_IDLE;
      S_UNDO:     next_state = S_UNDO_ACK;
      S_UNDO_ACK: next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  assign commit_err = err_q;
  assign game_over  = (&used_mask_p1) & (&used_mask_p2);

`ifdef SCORECARD_UNDO_EN
  logic             rec_valid;
  logic             rec_player;
  logic [CAT_W-1:0] rec_cat;
  logic             rec_bonus_before;

  // The score itself stays in the bank's register file; the record only needs
  // to know where it went and whether the bonus was already set beforehand.
  always_ff @(posedge clk) begin
    if (clear) begin
      rec_valid        <= 1'b0;
      rec_player       <= 1'b0;
      rec_cat          <= '0;
      rec_bonus_before <= 1'b0;
    end else if (state == S_WRITE) begin
      rec_valid        <= 1'b1;
      rec_player       <= player_q;
      rec_cat          <= cat_q;
      rec_bonus_before <= player_q ? bonus_p2 : bonus_p1;
    end else if (state == S_UNDO_ACK) begin
      rec_valid <= 1'b0;
    end
  end

  assign undo_start = undo_req & rec_valid;
  assign undo_p1    = (state == S_UNDO) & ~rec_player;
  assign undo_p2    = (state == S_UNDO) &  rec_player;
  assign undo_cat   = rec_cat;
  // Only the last commit can have raised the flag, so clear it if it was low before.
  assign undo_bonus = ~rec_bonus_before;
  assign undo_ack   = (state == S_UNDO_ACK);
`else
  assign undo_start = 1'b0;
  assign undo_p1    = 1'b0;
  assign undo_p2    = 1'b0;
  assign undo_cat   = '0;
  assign undo_bonus = 1'b0;
`endif

  score_bank u_bank_p1 (
    .clk        (clk),
    .clear      (clear),
    .wr_en      (wr_go & ~player_q),
    .wr_cat     (cat_q),
    .wr_score   (score_q),
    .undo_en    (undo_p1),
    .undo_cat   (undo_cat),
    .undo_bonus (undo_bonus),
    .used_mask  (used_mask_p1),
    .total      (p1_total),
    .bonus      (bonus_p1)
  );

  score_bank u_bank_p2 (
    .clk        (clk),
    .clear      (clear),
    .wr_en      (wr_go & player_q),
    .wr_cat     (cat_q),
    .wr_score   (score_q),
    .undo_en    (undo_p2),
    .undo_cat   (undo_cat),
    .undo_bonus (undo_bonus),
    .used_mask  (used_mask_p2),
    .total      (p2_total),
    .bonus      (bonus_p2)
  );

endmodule

// File: tb/tb_scorecard_manager.sv
// Self-checking bench for scorecard_manager.
// Reference model: per-player arrays of stored scores and used flags plus a
// bonus flag; totals and the upper sum are recomputed from the arrays.
// Undo checks are included when SCORECARD_UNDO_EN is defined.
module tb_scorecard_manager;
  import yacht_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         new_game = 1'b0;
  logic         player = 1'b0;
  logic [3:0]   cat_idx = '0;
  logic [7:0]   cand_score = '0;
  logic         commit_req = 1'b0;
  logic         commit_ack;
  logic         commit_err;
  logic         busy;
  logic [11:0]  used_mask_p1;
  logic [11:0]  used_mask_p2;
  logic [8:0]   p1_total;
  logic [8:0]   p2_total;
  logic         bonus_p1;
  logic         bonus_p2;
  logic         game_over;
`ifdef SCORECARD_UNDO_EN
  logic         undo_req = 1'b0;
  logic         undo_ack;
`endif

  always #5 clk = ~clk;

  scorecard_manager dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .player       (player),
    .cat_idx      (cat_idx),
    .cand_score   (cand_score),
    .commit_req   (commit_req),
`ifdef SCORECARD_UNDO_EN
    .undo_req     (undo_req),
    .undo_ack     (undo_ack),
`endif
    .commit_ack   (commit_ack),
    .commit_err   (commit_err),
    .busy         (busy),
    .used_mask_p1 (used_mask_p1),
    .used_mask_p2 (used_mask_p2),
    .p1_total     (p1_total),
    .p2_total     (p2_total),
    .bonus_p1     (bonus_p1),
    .bonus_p2     (bonus_p2),
    .game_over    (game_over)
  );

  // ---------------- scoreboard ----------------
  int         total_cnt = 0;
  int         bad_cnt = 0;
  logic [1:0] exp_q[$];   // expected {ack, err} per request

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_score [2][12];
  bit m_used  [2][12];
  bit m_bonus [2];
`ifdef SCORECARD_UNDO_EN
  bit m_last_valid;
  int m_last_p;
  int m_last_c;
  bit m_last_bonus;
`endif

  function automatic void m_clear();
    for (int p = 0; p < 2; p++) begin
      m_bonus[p] = 1'b0;
      for (int c = 0; c < 12; c++) begin
        m_score[p][c] = 0;
        m_used[p][c]  = 1'b0;
      end
    end
`ifdef SCORECARD_UNDO_EN
    m_last_valid = 1'b0;
`endif
  endfunction

  function automatic int m_total(input int p);
    int s = 0;
    for (int c = 0; c < 12; c++) s += m_score[p][c];
    if (m_bonus[p]) s += 35;
    return s % 512;
  endfunction

  function automatic logic [11:0] m_mask(input int p);
    logic [11:0] m = '0;
    for (int c = 0; c < 12; c++) m[c] = m_used[p][c];
    return m;
  endfunction

  function automatic bit m_done();
    return (m_mask(0) == 12'hfff) && (m_mask(1) == 12'hfff);
  endfunction

  // Returns 1 when the commit is legal (and applies it).
  function automatic bit m_commit(input int p, input int c, input int sc);
    int up = 0;
    if (c >= 12) return 1'b0;
    if (m_used[p][c]) return 1'b0;
    m_used[p][c]  = 1'b1;
    m_score[p][c] = sc;
    for (int i = 0; i < 6; i++) up += m_score[p][i];
`ifdef SCORECARD_UNDO_EN
    m_last_valid = 1'b1;
    m_last_p     = p;
    m_last_c     = c;
    m_last_bonus = 1'b0;
`endif
    if (!m_bonus[p] && up >= 63) begin
      m_bonus[p] = 1'b1;
`ifdef SCORECARD_UNDO_EN
      m_last_bonus = 1'b1;
`endif
    end
    return 1'b1;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".p1_total"}, 32'(p1_total), 32'(m_total(0)));
    chk({tag, ".p2_total"}, 32'(p2_total), 32'(m_total(1)));
    chk({tag, ".mask_p1"},  32'(used_mask_p1), 32'(m_mask(0)));
    chk({tag, ".mask_p2"},  32'(used_mask_p2), 32'(m_mask(1)));
    chk({tag, ".bonus_p1"}, 32'(bonus_p1), 32'(m_bonus[0]));
    chk({tag, ".bonus_p2"}, 32'(bonus_p2), 32'(m_bonus[1]));
    chk({tag, ".game_over"}, 32'(game_over), 32'(m_done()));
  endtask

  // ---------------- driver tasks ----------------
  // Request in cycle 0; result expected in cycle 3; idle by cycle 4.
  task automatic do_commit(input int p, input int c, input int sc, input string tag);
    logic [1:0] e;
    bit ok;
    ok = m_commit(p, c, sc);
    exp_q.push_back(ok ? 2'b10 : 2'b01);
    @(negedge clk);
    player = p[0]; cat_idx = c[3:0]; cand_score = sc[7:0]; commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    chk({tag, ".c1_resp"}, {30'b0, commit_ack, commit_err}, 32'd0);
    chk({tag, ".c1_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, ".c2_resp"}, {30'b0, commit_ack, commit_err}, 32'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".c3_resp"}, {30'b0, commit_ack, commit_err}, 32'(e));
    check_state(tag);
    @(negedge clk);
    chk({tag, ".c4_resp"}, {30'b0, commit_ack, commit_err}, 32'd0);
    chk({tag, ".c4_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic quiet_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ".quiet"}, {30'b0, commit_ack, commit_err}, 32'd0);
    end
  endtask

`ifdef SCORECARD_UNDO_EN
  task automatic do_undo(input string tag);
    bit exp_ack;
    exp_ack = m_last_valid;
    @(negedge clk);
    undo_req = 1'b1;
    @(negedge clk);
    undo_req = 1'b0;
    chk({tag, ".u1_ack"}, 32'(undo_ack), 32'd0);
    @(negedge clk);
    chk({tag, ".u2_ack"}, 32'(undo_ack), 32'(exp_ack));
    if (exp_ack) begin
      m_used[m_last_p][m_last_c]  = 1'b0;
      m_score[m_last_p][m_last_c] = 0;
      if (m_last_bonus) m_bonus[m_last_p] = 1'b0;
      m_last_valid = 1'b0;
    end
    check_state(tag);
    @(negedge clk);
    chk({tag, ".u3_ack"}, 32'(undo_ack), 32'd0);
  endtask
`endif

  // ---------------- directed + random sequence ----------------
  initial begin
    int pl[$];
    int tmp;
    int k;
    int last_p;
    int last_c;

    m_clear();

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset.resp", {30'b0, commit_ack, commit_err}, 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    check_state("reset");

    // P1 Choice = 23.
    do_commit(0, CAT_CHOICE, 23, "p1_choice");
    chk("p1_choice.total_23", 32'(p1_total), 32'd23);
    chk("p1_choice.mask_040", 32'(used_mask_p1), 32'h040);

    // Used category and out-of-range category are rejected.
    do_commit(0, CAT_CHOICE, 10, "p1_reuse");
    chk("p1_reuse.total_23", 32'(p1_total), 32'd23);
    do_commit(0, 12, 5, "cat12");

    // P2 upper section 3,6,...,18 crosses the bonus on the last one.
    for (int c = 0; c < 6; c++) begin
      do_commit(1, c, 3 * (c + 1), "p2_upper");
      if (c == 4) chk("p2_upper.no_bonus_yet", 32'(bonus_p2), 32'd0);
    end
    chk("p2_upper.bonus", 32'(bonus_p2), 32'd1);
    chk("p2_upper.total_98", 32'(p2_total), 32'd98);

    // Second request one cycle after the first is dropped.
    tmp = int'(m_commit(0, 3, 7));
    @(negedge clk);
    player = 1'b0; cat_idx = 4'd3; cand_score = 8'd7; commit_req = 1'b1;
    @(negedge clk);
    cat_idx = 4'd4; cand_score = 8'd9;
    @(negedge clk);
    commit_req = 1'b0;
    chk("overlap.c2_resp", {30'b0, commit_ack, commit_err}, 32'd0);
    @(negedge clk);
    chk("overlap.c3_resp", {30'b0, commit_ack, commit_err}, 32'({tmp[0], 1'b0}));
    check_state("overlap");
    quiet_cycles(4, "overlap_after");
    chk("overlap.cat4_unused", 32'(used_mask_p1[4]), 32'd0);

    // new_game during CHECK aborts the commit and clears both cards.
    @(negedge clk);
    player = 1'b0; cat_idx = 4'd5; cand_score = 8'd4; commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0; new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    m_clear();
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.p1_zero", 32'(p1_total), 32'd0);
    chk("abort.p2_zero", 32'(p2_total), 32'd0);
    check_state("abort");
    quiet_cycles(3, "abort_after");

    // new_game and commit_req together: new_game wins.
    @(negedge clk);
    player = 1'b1; cat_idx = 4'd0; cand_score = 8'd5; commit_req = 1'b1; new_game = 1'b1;
    @(negedge clk);
    commit_req = 1'b0; new_game = 1'b0;
    chk("ng_req.busy", 32'(busy), 32'd0);
    quiet_cycles(4, "ng_req_after");
    check_state("ng_req");

    // Random full game with interleaved illegal requests.
    for (int i = 0; i < 24; i++) pl.push_back(i);
    for (int i = 23; i > 0; i--) begin
      k = $urandom_range(0, i);
      tmp = pl[i]; pl[i] = pl[k]; pl[k] = tmp;
    end
    last_p = 0;
    last_c = 0;
    foreach (pl[i]) begin
      last_p = pl[i] / 12;
      last_c = pl[i] % 12;
      do_commit(last_p, last_c, $urandom_range(0, 40), "rand");
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1)
          do_commit($urandom_range(0, 1), $urandom_range(12, 15), $urandom_range(0, 40), "rand_badcat");
        else
          do_commit(last_p, last_c, $urandom_range(0, 40), "rand_reuse");
      end
    end
    chk("full.game_over", 32'(game_over), 32'd1);

`ifdef SCORECARD_UNDO_EN
    do_undo("undo_full");
    chk("undo_full.game_over", 32'(game_over), 32'd0);
    do_undo("undo_none");
    // Bonus-crossing commit undone removes the bonus.
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    m_clear();
    for (int c = 0; c < 5; c++) do_commit(0, c, 12, "undo_upper");
    do_commit(0, 5, 18, "undo_cross");
    chk("undo_cross.bonus", 32'(bonus_p1), 32'd1);
    do_undo("undo_bonus");
    chk("undo_bonus.bonus_off", 32'(bonus_p1), 32'd0);
    chk("undo_bonus.total_60", 32'(p1_total), 32'd60);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
